// File: rtl/sram_pattern_tester.sv
// Pattern-driven SRAM exerciser: writes then reads back an address range through the
// request/busy word interface, counting mismatches and capturing the first failing access.
module sram_pattern_tester #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned ERR_COUNT_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [1:0]                 pattern,
  input  logic                       stop_on_error,
  input  logic [WORD_WIDTH-1:0]      seed,
  input  logic [ADDRESS_WIDTH-1:0]   addr_first,
  input  logic [ADDRESS_WIDTH-1:0]   addr_last,
  output logic                       mem_request,
  input  logic                       mem_busy,
  input  logic                       mem_initialized,
  output logic [ADDRESS_WIDTH-1:0]   mem_address,
  output logic                       mem_write_enable,
  output logic [WORD_WIDTH-1:0]      mem_write_data,
  input  logic [WORD_WIDTH-1:0]      mem_read_data,
  output logic                       running,
  output logic                       done,
  output logic                       pass,
  output logic [ERR_COUNT_WIDTH-1:0] error_count,
  output logic [ADDRESS_WIDTH-1:0]   first_error_address,
  output logic [WORD_WIDTH-1:0]      first_error_expected,
  output logic [WORD_WIDTH-1:0]      first_error_actual
);

  typedef enum logic [2:0] {
    StIdle, StWaitInit, StIssue, StWaitBusy, StWaitDone, StCheck, StNext, StDone
  } state_e;

  state_e                     state_q;
  logic                       mode_q, stop_q, op_write_q;
  logic [1:0]                 pattern_q;
  logic [WORD_WIDTH-1:0]      seed_q, lfsr_q, rdata_q;
  logic [ADDRESS_WIDTH-1:0]   first_q, last_q, addr_q, idx_q;
  logic [WORD_WIDTH-1:0]      expected, lfsr_next, lfsr_seed;
  logic [ERR_COUNT_WIDTH-1:0] err_inc;
  logic                       mismatch, is_last;

  always_comb begin
    expected = lfsr_q;
    case (pattern_q)
      2'd0:    expected = seed_q + WORD_WIDTH'(idx_q);
      2'd1:    expected = WORD_WIDTH'(addr_q) ^ seed_q;
      2'd2:    expected = idx_q[0] ? ~seed_q : seed_q;
      default: expected = lfsr_q;
    endcase
  end

  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign lfsr_seed = (seed_q == '0) ? WORD_WIDTH'(1) : seed_q;
  assign err_inc   = (&error_count) ? error_count : error_count + 1'b1;
  assign mismatch  = (rdata_q != expected);
  assign is_last   = (addr_q == last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= StIdle;
      mode_q               <= 1'b0;
      stop_q               <= 1'b0;
      op_write_q           <= 1'b0;
      pattern_q            <= '0;
      seed_q               <= '0;
      lfsr_q               <= '0;
      rdata_q              <= '0;
      first_q              <= '0;
      last_q               <= '0;
      addr_q               <= '0;
      idx_q                <= '0;
      mem_request          <= 1'b0;
      mem_address          <= '0;
      mem_write_enable     <= 1'b0;
      mem_write_data       <= '0;
      running              <= 1'b0;
      done                 <= 1'b0;
      pass                 <= 1'b0;
      error_count          <= '0;
      first_error_address  <= '0;
      first_error_expected <= '0;
      first_error_actual   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mode_q               <= mode;
            stop_q               <= stop_on_error;
            pattern_q            <= pattern;
            seed_q               <= seed;
            lfsr_q               <= (seed == '0) ? WORD_WIDTH'(1) : seed;
            first_q              <= addr_first;
            last_q               <= addr_last;
            addr_q               <= addr_first;
            idx_q                <= '0;
            op_write_q           <= 1'b1;
            running              <= 1'b1;
            done                 <= 1'b0;
            pass                 <= 1'b0;
            error_count          <= '0;
            first_error_address  <= '0;
            first_error_expected <= '0;
            first_error_actual   <= '0;
            state_q              <= StWaitInit;
          end
        end
        StWaitInit: if (mem_initialized) state_q <= StIssue;
        StIssue: begin
          if (!mem_initialized) begin
            state_q <= StWaitInit;
          end else if (!mem_busy) begin
            mem_request      <= 1'b1;
            mem_address      <= addr_q;
            mem_write_enable <= op_write_q;
            mem_write_data   <= expected;
            state_q          <= StWaitBusy;
          end
        end
        StWaitBusy: if (mem_busy) state_q <= StWaitDone;
        StWaitDone: begin
          if (!mem_busy) begin
            mem_request <= 1'b0;
            rdata_q     <= mem_read_data;
            state_q     <= mem_write_enable ? StNext : StCheck;
          end
        end
        StCheck: begin
          if (mismatch) begin
            error_count <= err_inc;
            if (error_count == '0) begin
              first_error_address  <= addr_q;
              first_error_expected <= expected;
              first_error_actual   <= rdata_q;
            end
          end
          if (mismatch && stop_q) begin
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state_q <= StDone;
          end else begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (!mode_q && op_write_q) begin
            op_write_q <= 1'b0;
            state_q    <= StIssue;
          end else if (!is_last) begin
            idx_q      <= idx_q + 1'b1;
            addr_q     <= addr_q + 1'b1;
            lfsr_q     <= lfsr_next;
            op_write_q <= !mode_q || op_write_q;
            state_q    <= StIssue;
          end else if (mode_q && op_write_q) begin
            // Block mode: rewind the walk for the read-back phase.
            idx_q      <= '0;
            addr_q     <= first_q;
            lfsr_q     <= lfsr_seed;
            op_write_q <= 1'b0;
            state_q    <= StIssue;
          end else begin
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= (error_count == '0);
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester: busy-handshake SRAM model with optional read fault and a
// scoreboard of expected transactions built from an independent pattern model.
module tb_sram_pattern_tester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, mode = 1'b0, stop_on_error = 1'b0;
  logic [1:0]  pattern = '0;
  logic [15:0] seed = '0, addr_first = '0, addr_last = '0;
  logic        mem_request, mem_busy, mem_initialized, mem_write_enable;
  logic [15:0] mem_address, mem_write_data, mem_read_data;
  logic        running, done, pass;
  logic [15:0] error_count, first_error_address, first_error_expected, first_error_actual;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_pattern_tester dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .mode                 (mode),
    .pattern              (pattern),
    .stop_on_error        (stop_on_error),
    .seed                 (seed),
    .addr_first           (addr_first),
    .addr_last            (addr_last),
    .mem_request          (mem_request),
    .mem_busy             (mem_busy),
    .mem_initialized      (mem_initialized),
    .mem_address          (mem_address),
    .mem_write_enable     (mem_write_enable),
    .mem_write_data       (mem_write_data),
    .mem_read_data        (mem_read_data),
    .running              (running),
    .done                 (done),
    .pass                 (pass),
    .error_count          (error_count),
    .first_error_address  (first_error_address),
    .first_error_expected (first_error_expected),
    .first_error_actual   (first_error_actual)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        sb[$];
  txn_t        exp_txn;
  logic [15:0] mem [0:65535];
  logic        req_q, active, cap_we;
  logic [15:0] cap_addr, cap_data;
  int          bcnt;
  bit          fault_en = 1'b0;

  // SRAM model: accept on request rise, busy high for 3 cycles, complete when busy drops.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy      <= 1'b0;
      mem_read_data <= '0;
      req_q         <= 1'b0;
      active        <= 1'b0;
      bcnt          <= 0;
    end else begin
      req_q <= mem_request;
      if (!active) begin
        if (mem_request && !req_q) begin
          active   <= 1'b1;
          bcnt     <= 0;
          cap_we   <= mem_write_enable;
          cap_addr <= mem_address;
          cap_data <= mem_write_data;
          check_eq("sb_txn_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_txn = sb.pop_front();
            check_eq("txn_we", 64'(mem_write_enable), 64'(exp_txn.we));
            check_eq("txn_addr", 64'(mem_address), 64'(exp_txn.addr));
            if (exp_txn.we) check_eq("txn_wdata", 64'(mem_write_data), 64'(exp_txn.data));
          end
        end
      end else begin
        bcnt <= bcnt + 1;
        if (bcnt == 0) begin
          mem_busy <= 1'b1;
        end else if (bcnt == 3) begin
          mem_busy <= 1'b0;
          active   <= 1'b0;
          check_eq("txn_stable", 64'({mem_request, mem_write_enable, mem_address, mem_write_data}),
                   64'({1'b1, cap_we, cap_addr, cap_data}));
          if (cap_we) mem[cap_addr] <= cap_data;
          else mem_read_data <= (fault_en && cap_addr == 16'h0004) ? 16'hDEAD : mem[cap_addr];
        end
      end
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Fills the scoreboard and returns expected error summary for one run.
  task automatic build_exp(input bit md, input logic [1:0] pt, input bit stp, input logic [15:0] sd,
                           input logic [15:0] fa, input logic [15:0] la, input bit flt,
                           output int exp_err, output logic [15:0] fe_addr,
                           output logic [15:0] fe_exp);
    logic [15:0] span, a, lf;
    logic [15:0] av[$], dv[$];
    int n;
    span = la - fa;
    n = int'(span) + 1;
    lf = (sd == 16'h0) ? 16'h0001 : sd;
    for (int i = 0; i < n; i++) begin
      a = fa + 16'(i);
      av.push_back(a);
      case (pt)
        2'd0: dv.push_back(sd + 16'(i));
        2'd1: dv.push_back(a ^ sd);
        2'd2: dv.push_back((i % 2 == 1) ? ~sd : sd);
        default: dv.push_back(lf);
      endcase
      lf = lfsr_step(lf);
    end
    exp_err = 0;
    fe_addr = '0;
    fe_exp  = '0;
    if (md) for (int i = 0; i < n; i++) sb.push_back({1'b1, av[i], dv[i]});
    for (int i = 0; i < n; i++) begin
      if (!md) sb.push_back({1'b1, av[i], dv[i]});
      sb.push_back({1'b0, av[i], dv[i]});
      if (flt && av[i] == 16'h0004) begin
        if (exp_err == 0) begin
          fe_addr = av[i];
          fe_exp  = dv[i];
        end
        exp_err++;
        if (stp) break;
      end
    end
  endtask

  task automatic run_test(input string name, input bit md, input logic [1:0] pt, input bit stp,
                          input logic [15:0] sd, input logic [15:0] fa, input logic [15:0] la,
                          input bit flt, input bit poke, input int init_delay);
    int exp_err, cyc;
    logic [15:0] fe_addr, fe_exp;
    bit saw_req;
    build_exp(md, pt, stp, sd, fa, la, flt, exp_err, fe_addr, fe_exp);
    fault_en = flt;
    @(negedge clk);
    if (init_delay > 0) mem_initialized = 1'b0;
    mode = md; pattern = pt; stop_on_error = stp; seed = sd; addr_first = fa; addr_last = la;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, "_running"}, 64'(running), 64'd1);
    check_eq({name, "_done_cleared"}, 64'(done), 64'd0);
    if (init_delay > 0) begin
      saw_req = 1'b0;
      repeat (init_delay) begin
        @(negedge clk);
        saw_req |= mem_request;
      end
      check_eq({name, "_init_gate"}, 64'(saw_req), 64'd0);
      mem_initialized = 1'b1;
    end
    if (poke) begin
      repeat (7) @(negedge clk);
      seed = ~seed; addr_last = addr_first; mode = ~mode; pattern = pattern + 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "_done_in_time"}, 64'(cyc < 5000), 64'd1);
    repeat (12) @(negedge clk);
    check_eq({name, "_done"}, 64'({done, running, mem_request}), 64'b100);
    check_eq({name, "_pass"}, 64'(pass), 64'(exp_err == 0));
    check_eq({name, "_err_count"}, 64'(error_count), 64'(exp_err));
    check_eq({name, "_fe_addr"}, 64'(first_error_address), 64'(fe_addr));
    check_eq({name, "_fe_exp"}, 64'(first_error_expected), 64'(fe_exp));
    check_eq({name, "_fe_act"}, 64'(first_error_actual), 64'(exp_err > 0 ? 16'hDEAD : 16'h0));
    check_eq({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int cyc, exp_err;
    logic [15:0] fe_addr, fe_exp;
    mem_initialized = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", 64'({mem_request, mem_write_enable, running, done, pass}), 64'd0);
    check_eq("reset_bus", 64'({mem_address, mem_write_data, error_count}), 64'd0);
    reset = 1'b0;

    run_test("interleaved_p0", 1'b0, 2'd0, 1'b0, 16'h650F, 16'h1536, 16'h1538, 1'b0, 1'b0, 5);
    run_test("block_lfsr", 1'b1, 2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0007, 1'b0, 1'b0, 0);
    run_test("fault_nostop", 1'b0, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0009, 1'b1, 1'b0, 0);
    run_test("fault_stop", 1'b1, 2'd1, 1'b1, 16'h0000, 16'h0000, 16'h0009, 1'b1, 1'b0, 0);
    run_test("wrap_checker", 1'b0, 2'd2, 1'b0, 16'hAAAA, 16'hFFFE, 16'h0001, 1'b0, 1'b1, 0);

    // Reset while a request is outstanding, after a mismatch has been recorded.
    build_exp(1'b0, 2'd1, 1'b0, 16'h0000, 16'h0000, 16'h0009, 1'b1, exp_err, fe_addr, fe_exp);
    fault_en = 1'b1;
    @(negedge clk);
    mode = 1'b0; pattern = 2'd1; stop_on_error = 1'b0; seed = 16'h0; addr_first = 16'h0;
    addr_last = 16'h9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(error_count != 0 && mem_request && mem_write_enable) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_setup_reached", 64'(cyc < 2000), 64'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_async_ctl", 64'({mem_request, mem_write_enable, running, done, pass}), 64'd0);
    check_eq("rst_async_bus", 64'({mem_address, mem_write_data, error_count}), 64'd0);
    check_eq("rst_async_fe",
             64'({first_error_address, first_error_expected, first_error_actual}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();

    run_test("after_reset", 1'b0, 2'd0, 1'b0, 16'h650F, 16'h1536, 16'h1538, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pattern_tester.md
# sram_pattern_tester

Self-checking SRAM exerciser that drives the request/busy word interface of the SPI SRAM encoder (address, write enable, write data, read data). It writes then reads back a programmable address range using one of four data patterns, in interleaved or block mode, counts mismatches and captures the first failing access. It sits between board-level controls (buttons, LEDs) and the encoder in FPGA bring-up builds, and is the parametrised successor of the fixed write/read/compare loop.

## Interface
- WORD_WIDTH, 16, data word width
- ADDRESS_WIDTH, 16, address width
- ERR_COUNT_WIDTH, 16, error counter width
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask, WORD_WIDTH bits
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; begins a run when idle or done
- mode  in  1  0 = interleaved (write then read each address), 1 = block (write whole range, then read whole range)
- pattern  in  2  0 = seed+index, 1 = address^seed, 2 = checkerboard, 3 = LFSR
- stop_on_error  in  1  end run on first mismatch
- seed  in  WORD_WIDTH  pattern seed
- addr_first, addr_last  in  ADDRESS_WIDTH  inclusive range
- mem_request  out  1  transaction request to encoder
- mem_busy, mem_initialized  in  1  encoder status
- mem_address  out  ADDRESS_WIDTH
- mem_write_enable  out  1  1 = write, 0 = read
- mem_write_data  out  WORD_WIDTH
- mem_read_data  in  WORD_WIDTH
- running, done, pass  out  1  status
- error_count  out  ERR_COUNT_WIDTH  saturating mismatch count
- first_error_address  out  ADDRESS_WIDTH
- first_error_expected, first_error_actual  out  WORD_WIDTH

## Operation
- start, mode, pattern, stop_on_error, seed, addr_first, addr_last sampled on the start cycle; held internally for the run. start while running is ignored.
- Range: N = ((addr_last - addr_first) mod 2^ADDRESS_WIDTH) + 1; addresses increment and wrap through max to 0. addr_first == addr_last: one address.
- Pattern at index i (0..N-1), address a: 0: seed + i (mod 2^WORD_WIDTH); 1: a zero-extended/truncated to WORD_WIDTH, XOR seed; 2: seed for even i, ~seed for odd i; 3: LFSR state, initialised to seed (0 replaced by 1), advanced once per index; restarted from seed at start of block-mode read phase.
- States: IDLE -> WAIT_INIT (until mem_initialized) -> ISSUE -> WAIT_BUSY (busy high seen) -> WAIT_DONE (busy low) -> CHECK (reads only) -> NEXT -> ISSUE or DONE.
- Interleaved: per address write, read, check, advance. Block: N writes, then N reads with checks.
- Mismatch (read data != expected): error_count increments, saturating at all ones; first mismatch of the run loads first_error_* registers. If stop_on_error, go to DONE after CHECK.
- DONE: done=1, running=0, pass = (error_count == 0); held until next start, which clears error_count, first_error_*, done, pass.

## Timing
- Reset values: mem_request 0, mem_address 0, mem_write_enable 0, mem_write_data 0, running 0, done 0, pass 0, error_count 0, first_error_* 0; state IDLE. Reset mid-transaction drops mem_request immediately.
- start edge -> running=1 next cycle; mem_request high in the cycle after ISSUE is entered with mem_initialized=1.
- mem_address, mem_write_enable, mem_write_data stable from mem_request rise until transaction completes.
- Completion: first cycle mem_busy is low after having been high during the request; mem_request deasserts on that edge and mem_read_data is registered on that edge.
- CHECK is 1 cycle after completion; next mem_request no earlier than 2 cycles after completion (requires mem_busy low).
- mem_initialized falling mid-run: current transaction completes; next ISSUE waits for re-initialisation.

## Test plan
- Interleaved, pattern 0, seed 16'h650F, range 16'h1536..16'h1538, ideal model (busy 3 cycles) -> 6 transactions alternating W/R, writes 650F,6510,6511, done=1, pass=1, error_count 0.
- Block, pattern 3, seed 0, range 0..7 -> 8 writes then 8 reads in order, LFSR sequence from 1 repeated in read phase, pass=1.
- Model corrupts read of address 16'h0004 to 16'hDEAD, pattern 1 seed 0, range 0..9, stop_on_error 0 -> error_count 1, first_error_address 4, expected 0004, actual DEAD, 10 reads done, pass=0.
- Same fault with stop_on_error 1 -> done after read of address 4; no further mem_request; pass=0.
- Range 16'hFFFE..16'h0001, pattern 2 seed 16'hAAAA -> addresses FFFE,FFFF,0000,0001; data AAAA,5555,AAAA,5555.
- Reset asserted while mem_request high, and start pulsed during a run -> all outputs at reset values asynchronously; mid-run start has no effect.
